core_pipe_exec_mdu_iter: RTL and testbench
==========================================

Name: core_pipe_exec_mdu_iter

Overview:
Parametrised iterative RISC-V M-extension multiply/divide unit for the execute stage. Supports configurable XLEN (32/64), configurable bits-per-cycle for multiply and divide, and a fast path for divide-by-zero and signed overflow. Requests and responses use explicit valid/ready handshakes, so the result is held under writeback back-pressure.

Parameters:
XLEN, 64, datapath width; 32 or 64. Word ops (op_word) are legal only when XLEN=64.
MUL_UNROLL, 2, multiplier bits retired per cycle; 1, 2, 4 or 8; must divide the operand width.
DIV_UNROLL, 1, quotient bits retired per cycle; 1 or 2.

Ports:
g_clk  in  1  clock
g_resetn  in  1  synchronous active-low reset
flush  in  1  abort current operation
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
op_word  in  1  32-bit word op; result sign-extended
op_sel  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1  in  XLEN  operand 1 / dividend
rs2  in  XLEN  operand 2 / divisor
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_rd  out  XLEN  result
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: clock is g_clk. Reset is g_resetn, synchronous, active-low.
- Reset values: state=IDLE, rsp_valid=0, rsp_rd=0, busy=0. req_ready=1 once out of reset.
- Accept: a request is accepted on an edge where req_valid && req_ready.
  - req_ready = (state==IDLE) && !flush.
  - op_sel, op_word, rs1 and rs2 are captured at acceptance; later input changes have no effect.
- Operand width: W = op_word ? 32 : XLEN.
- States: IDLE, MUL, DIV, FIXUP, DONE.
  - IDLE -> MUL: accept with op_sel<4.
  - IDLE -> DIV: accept with op_sel>=4 and not a special case.
  - IDLE -> DONE: accept of a special case.
  - MUL: runs exactly W/MUL_UNROLL cycles -> DONE.
  - DIV: runs exactly W/DIV_UNROLL cycles -> FIXUP (1 cycle) -> DONE.
  - DONE: rsp_valid=1. DONE -> IDLE on rsp_ready.
- Latency, counted as edges from acceptance to rsp_valid high:
  - MUL: W/MUL_UNROLL + 1.
  - DIV: W/DIV_UNROLL + 2.
  - Special case: 1.
- Multiply: shift-add on a 2W-bit accumulator plus a W-bit multiplier shift register.
  - Signed operands are handled by sign-extending the partial sum and subtracting on the final multiplier MSB when rs2 is signed.
  - Selection: MUL returns low W bits; MULH/MULHSU/MULHU return high W bits.
  - Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
- Divide: restoring division on magnitudes.
  - FIXUP negates the quotient if operand signs differ (signed ops).
  - FIXUP negates the remainder if the dividend is negative (signed ops).
- Special cases (fast path, no iteration):
  - Divisor==0: DIV/DIVU -> all ones (W bits); REM/REMU -> rs1 (W bits).
  - Signed overflow (rs1 = -2^(W-1), rs2 = -1, DIV/REM only): DIV -> rs1; REM -> 0.
- op_word: the result is bits [31:0] sign-extended from bit 31, for every op.
- Response: rsp_rd and rsp_valid are registered and held stable while rsp_valid && !rsp_ready. A new request cannot be accepted in the same cycle as the response handshake; req_ready rises the cycle after.
- flush:
  - Any state -> IDLE on the next edge; rsp_valid=0 next cycle; no response is produced for the aborted op.
  - flush has priority over req_valid and rsp_ready.
  - rsp_rd keeps its last value (don't care).
- Reset mid-operation: identical to flush, and also clears rsp_rd to 0.
- Illegal: op_word with XLEN=32 is not allowed; assertion in simulation only.

Test Plan:
1. XLEN=64, MUL_UNROLL=2, MULH rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 -> rsp_rd=0xFFFF_FFFF_FFFF_FFFF, rsp_valid 33 edges after accept. MULHU with the same operands -> 0x1. MUL with the same operands -> 0xFFFF_FFFF_FFFF_FFFE.
2. DIV rs1=-7, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -> 0xFFFF_FFFF_FFFF_FFFF (-1); DIV latency 66 with DIV_UNROLL=1. DIVU 100/7 -> 14; REMU -> 2.
3. Special cases:
   - DIVU rs1=123, rs2=0 -> all ones.
   - REM rs1=-7, rs2=0 -> 0xFFFF_FFFF_FFFF_FFF9.
   - DIVW rs1=0x8000_0000, rs2=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
   - REMW with the same operands -> 0.
   - All four: rsp_valid 1 edge after accept.
4. MULW rs1=0x7FFF_FFFF, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFE, latency 17; upper operand bits set to random values have no effect.
5. Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_rd stable, req_ready=0, busy=1. After rsp_ready=1: req_ready=1 the next cycle.
6. Flush: assert flush 10 cycles into DIVU 1000/3 -> rsp_valid never rises, req_ready=1 next cycle. Following MUL 6×7 -> 42 with normal latency. flush coincident with req_valid in IDLE -> request not accepted.

Source files
------------

// File: rtl/core_pipe_exec_mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit for the execute stage (XLEN 32/64, word ops on 64).
// Latency from accept: MUL W/MUL_UNROLL+1, DIV/REM W/DIV_UNROLL+2, divide-by-zero/overflow 1 edge.
// Backpressure: result held in DONE until rsp_ready; req_ready low whenever not IDLE or while flushing.
module core_pipe_exec_mdu_iter #(
   parameter int XLEN       = 64,
   parameter int MUL_UNROLL = 2,
   parameter int DIV_UNROLL = 1
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            op_word,
   input  logic [2:0]      op_sel,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rd,
   output logic            busy
);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

   localparam int CNT_W = $clog2(XLEN) + 1;
   // Iteration counts are loaded as (cycles - 1) and the last cycle is the one where cnt == 0.
   localparam logic [CNT_W-1:0] MUL_CYC_X = CNT_W'(XLEN / MUL_UNROLL - 1);
   localparam logic [CNT_W-1:0] MUL_CYC_W = CNT_W'(32 / MUL_UNROLL - 1);
   localparam logic [CNT_W-1:0] DIV_CYC_X = CNT_W'(XLEN / DIV_UNROLL - 1);
   localparam logic [CNT_W-1:0] DIV_CYC_W = CNT_W'(32 / DIV_UNROLL - 1);

   // Replace bits above 31 with a sign or zero extension of bit 31 when operating on words.
   function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v,
                                                 input logic            word,
                                                 input logic            sgn);
      logic [XLEN-1:0] r;
      r = v;
      if (word) begin
         for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
      end
      return r;
   endfunction

   state_t            state;
   logic [CNT_W-1:0]  cnt;

   // Captured operation attributes
   logic              word_q;
   logic              mul_lo_q;
   logic              mul_neg_q;
   logic              rem_q;
   logic              qneg_q;
   logic              rneg_q;

   // Multiplier datapath: product accumulator, left-shifting multiplicand, right-shifting multiplier
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;

   // Divider datapath: dividend/quotient shift register, partial remainder, divisor magnitude
   logic [XLEN-1:0]   div_q;
   logic [XLEN-1:0]   div_r;
   logic [XLEN-1:0]   div_d;

   logic              accept;
   logic              req_div;
   logic              req_s1;
   logic              req_s2;
   logic              req_neg1;
   logic              req_neg2;
   logic              req_zero;
   logic              req_ovf;
   logic              req_special;
   logic [XLEN-1:0]   req_a;
   logic [XLEN-1:0]   req_b;
   logic [XLEN-1:0]   req_mag1;
   logic [XLEN-1:0]   req_mag2;
   logic [XLEN-1:0]   req_min;
   logic [XLEN-1:0]   req_spec_res;

   logic [2*XLEN-1:0] m_acc;
   logic [2*XLEN-1:0] m_cand;
   logic [XLEN-1:0]   m_plier;

   logic [XLEN-1:0]   d_q;
   logic [XLEN-1:0]   d_r;
   logic [XLEN:0]     d_t;

   logic [XLEN-1:0]   mul_res;
   logic [XLEN-1:0]   div_res;

   assign req_ready = (state == S_IDLE) && !flush;
   assign accept    = req_valid && req_ready;
   assign busy      = (state != S_IDLE);

   // Decode the incoming request: operand signedness, magnitudes and the divide fast-path cases.
   always_comb begin
      req_div  = op_sel[2];
      req_s1   = (op_sel == 3'd1) || (op_sel == 3'd2) || (op_sel == 3'd4) || (op_sel == 3'd6);
      req_s2   = (op_sel == 3'd1) || (op_sel == 3'd4) || (op_sel == 3'd6);
      req_a    = word_ext(rs1, op_word, req_s1);
      req_b    = word_ext(rs2, op_word, req_s2);
      req_neg1 = req_s1 & req_a[XLEN-1];
      req_neg2 = req_s2 & req_b[XLEN-1];
      req_mag1 = req_neg1 ? -req_a : req_a;
      req_mag2 = req_neg2 ? -req_b : req_b;
      // Most negative W-bit value, extended to XLEN the same way req_a is
      req_min  = '0;
      if (op_word) begin
         for (int i = 31; i < XLEN; i++) req_min[i] = 1'b1;
      end else begin
         req_min[XLEN-1] = 1'b1;
      end
      req_zero    = (req_b == '0);
      req_ovf     = req_div && req_s1 && (req_a == req_min) && (req_b == '1);
      req_special = req_div && (req_zero || req_ovf);
      if (req_zero) begin
         req_spec_res = op_sel[1] ? rs1 : '1;
      end else begin
         req_spec_res = op_sel[1] ? '0 : rs1;
      end
   end

   // One multiply iteration: add (or subtract for a signed multiplier MSB) per retired multiplier bit.
   always_comb begin
      m_acc   = acc;
      m_cand  = mcand;
      m_plier = mplier;
      for (int k = 0; k < MUL_UNROLL; k++) begin
         if (m_plier[0]) begin
            if (mul_neg_q && (cnt == '0) && (k == MUL_UNROLL - 1)) begin
               m_acc = m_acc - m_cand;
            end else begin
               m_acc = m_acc + m_cand;
            end
         end
         m_cand  = m_cand << 1;
         m_plier = m_plier >> 1;
      end
   end

   // One restoring-divide iteration: shift in the next dividend bit, subtract the divisor if it fits.
   always_comb begin
      d_q = div_q;
      d_r = div_r;
      d_t = '0;
      for (int k = 0; k < DIV_UNROLL; k++) begin
         d_t = {d_r, d_q[XLEN-1]};
         d_q = d_q << 1;
         if (d_t >= {1'b0, div_d}) begin
            d_t    = d_t - {1'b0, div_d};
            d_q[0] = 1'b1;
         end
         d_r = d_t[XLEN-1:0];
      end
   end

   // Result selection: product half for multiplies, sign-corrected quotient/remainder for divides.
   always_comb begin
      if (mul_lo_q) begin
         mul_res = m_acc[XLEN-1:0];
      end else if (word_q) begin
         mul_res = XLEN'(m_acc[63:32]);
      end else begin
         mul_res = m_acc[2*XLEN-1:XLEN];
      end
      if (rem_q) begin
         div_res = rneg_q ? -div_r : div_r;
      end else begin
         div_res = qneg_q ? -div_q : div_q;
      end
   end

   // Control FSM with registered response; flush aborts, reset also clears the result.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_rd    <= '0;
      end else if (flush) begin
         state     <= S_IDLE;
         rsp_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (req_special) begin
                     rsp_rd    <= word_ext(req_spec_res, op_word, 1'b1);
                     rsp_valid <= 1'b1;
                     state     <= S_DONE;
                  end else if (req_div) begin
                     cnt   <= op_word ? DIV_CYC_W : DIV_CYC_X;
                     state <= S_DIV;
                  end else begin
                     cnt   <= op_word ? MUL_CYC_W : MUL_CYC_X;
                     state <= S_MUL;
                  end
               end
            end
            S_MUL: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  rsp_rd    <= word_ext(mul_res, word_q, 1'b1);
                  rsp_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DIV: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0) state <= S_FIXUP;
            end
            S_FIXUP: begin
               rsp_rd    <= word_ext(div_res, word_q, 1'b1);
               rsp_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Datapath: load operands on accept, then iterate while in MUL or DIV; no reset needed.
   always_ff @(posedge g_clk) begin
      if (accept) begin
         word_q    <= op_word;
         mul_lo_q  <= (op_sel == 3'd0);
         mul_neg_q <= req_s2 && !req_div;
         rem_q     <= op_sel[1];
         qneg_q    <= req_neg1 ^ req_neg2;
         rneg_q    <= req_neg1;
         acc       <= '0;
         mcand     <= {{XLEN{req_neg1}}, req_a};
         mplier    <= req_b;
         // Word dividends are left-aligned so the first shifted-out bit is bit 31.
         div_q     <= op_word ? (req_mag1 << (XLEN - 32)) : req_mag1;
         div_r     <= '0;
         div_d     <= req_mag2;
      end else if (state == S_MUL) begin
         acc    <= m_acc;
         mcand  <= m_cand;
         mplier <= m_plier;
      end else if (state == S_DIV) begin
         div_q <= d_q;
         div_r <= d_r;
      end
   end

   // Word ops only exist on a 64-bit datapath.
   always_ff @(posedge g_clk) begin
      if (g_resetn && accept) begin
         assert (!(op_word && (XLEN == 32)));
      end
   end

endmodule

// File: tb/tb_core_pipe_exec_mdu_iter.sv
`timescale 1ns/1ps
module tb_core_pipe_exec_mdu_iter;

   localparam int TMO = 200;

   logic        g_clk;
   logic        g_resetn;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic        op_word;
   logic [2:0]  op_sel;
   logic [63:0] rs1;
   logic [63:0] rs2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rd;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   core_pipe_exec_mdu_iter #(.XLEN(64), .MUL_UNROLL(2), .DIV_UNROLL(1)) dut (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .op_word   (op_word),
      .op_sel    (op_sel),
      .rs1       (rs1),
      .rs2       (rs2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rd    (rsp_rd),
      .busy      (busy)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
      $fatal(1);
   end

   // Issue one request from idle, scramble inputs after accept, wait for the result, then take it.
   task automatic run_op(input logic [2:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, output int lat, output logic [63:0] res);
      op_sel    = op;
      op_word   = word;
      rs1       = a;
      rs2       = b;
      req_valid = 1'b1;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      op_sel    = 3'($urandom);
      op_word   = 1'($urandom);
      rs1       = {$urandom, $urandom};
      rs2       = {$urandom, $urandom};
      lat = 1;
      while (!rsp_valid && lat < TMO) begin
         @(posedge g_clk); #1;
         lat++;
      end
      res = rsp_rd;
      rsp_ready = 1'b1;
      @(posedge g_clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      g_resetn  = 1'b0;
      flush     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      op_word   = 1'b0;
      op_sel    = 3'd0;
      rs1       = '0;
      rs2       = '0;
      repeat (3) @(posedge g_clk);
      #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (rsp_rd !== 64'h0) begin n_err++; $display("FAIL reset_rsp_rd: got %h want 0", rsp_rd); end
      g_resetn = 1'b1;
      @(posedge g_clk); #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_mul();
      int lat;
      logic [63:0] res;
      run_op(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, res);
      n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL mulh_res: got %h want ffffffffffffffff", res); end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mulh_lat: got %0d want 33", lat); end
      run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, res);
      n_cmp++; if (res !== 64'h1) begin n_err++; $display("FAIL mulhu_res: got %h want 1", res); end
      run_op(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, res);
      n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL mul_res: got %h want fffffffffffffffe", res); end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_lat: got %0d want 33", lat); end
      // -1 * 2^63 as signed x unsigned is -2^63: high half all ones
      run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, lat, res);
      n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL mulhsu_res: got %h want ffffffffffffffff", res); end
      // -1 * -2^63 as signed x signed is +2^63: high half zero
      run_op(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, lat, res);
      n_cmp++; if (res !== 64'h0) begin n_err++; $display("FAIL mulh_negmsb_res: got %h want 0", res); end
   endtask

   task automatic test_div();
      int lat;
      logic [63:0] res;
      run_op(3'd4, 1'b0, -64'sd7, 64'd2, lat, res);
      n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_res: got %h want fffffffffffffffd", res); end
      n_cmp++; if (lat !== 66) begin n_err++; $display("FAIL div_lat: got %0d want 66", lat); end
      run_op(3'd6, 1'b0, -64'sd7, 64'd2, lat, res);
      n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL rem_res: got %h want ffffffffffffffff", res); end
      run_op(3'd5, 1'b0, 64'd100, 64'd7, lat, res);
      n_cmp++; if (res !== 64'd14) begin n_err++; $display("FAIL divu_res: got %0d want 14", res); end
      run_op(3'd7, 1'b0, 64'd100, 64'd7, lat, res);
      n_cmp++; if (res !== 64'd2) begin n_err++; $display("FAIL remu_res: got %0d want 2", res); end
      // DIVW -7/2 with junk in the upper halves: -3 sign-extended, 32 iterations + 2
      run_op(3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hDEAD_BEEF_0000_0002, lat, res);
      n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL divw_res: got %h want fffffffffffffffd", res); end
      n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL divw_lat: got %0d want 34", lat); end
   endtask

   task automatic test_special();
      int lat;
      logic [63:0] res;
      run_op(3'd5, 1'b0, 64'd123, 64'd0, lat, res);
      n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL divu_zero_res: got %h want ffffffffffffffff", res); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL divu_zero_lat: got %0d want 1", lat); end
      run_op(3'd6, 1'b0, -64'sd7, 64'd0, lat, res);
      n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFF9) begin n_err++; $display("FAIL rem_zero_res: got %h want fffffffffffffff9", res); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rem_zero_lat: got %0d want 1", lat); end
      run_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, lat, res);
      n_cmp++; if (res !== 64'hFFFF_FFFF_8000_0000) begin n_err++; $display("FAIL divw_ovf_res: got %h want ffffffff80000000", res); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL divw_ovf_lat: got %0d want 1", lat); end
      run_op(3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, lat, res);
      n_cmp++; if (res !== 64'h0) begin n_err++; $display("FAIL remw_ovf_res: got %h want 0", res); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL remw_ovf_lat: got %0d want 1", lat); end
   endtask

   task automatic test_word_mul();
      int lat;
      logic [63:0] res;
      for (int i = 0; i < 2; i++) begin
         run_op(3'd0, 1'b1, {$urandom, 32'h7FFF_FFFF}, {$urandom, 32'h0000_0002}, lat, res);
         n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL mulw_res[%0d]: got %h want fffffffffffffffe", i, res); end
         n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL mulw_lat[%0d]: got %0d want 17", i, lat); end
      end
   endtask

   task automatic test_backpressure();
      int wait_cnt;
      op_sel    = 3'd0;
      op_word   = 1'b0;
      rs1       = 64'd6;
      rs2       = 64'd7;
      req_valid = 1'b1;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      wait_cnt  = 0;
      while (!rsp_valid && wait_cnt < TMO) begin
         @(posedge g_clk); #1;
         wait_cnt++;
      end
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); end
      // A competing request during the stall must be ignored
      req_valid = 1'b1;
      op_sel    = 3'd5;
      rs1       = 64'd99;
      rs2       = 64'd3;
      for (int i = 0; i < 5; i++) begin
         @(posedge g_clk); #1;
         n_cmp++; if (rsp_rd !== 64'd42) begin n_err++; $display("FAIL bp_rsp_rd[%0d]: got %0d want 42", i, rsp_rd); end
         n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy[%0d]: got %b want 1", i, busy); end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge g_clk); #1;
      rsp_ready = 1'b0;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_req_ready: got %b want 1", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_rsp_valid: got %b want 0", rsp_valid); end
   endtask

   task automatic test_flush();
      int lat;
      logic [63:0] res;
      logic seen;
      op_sel    = 3'd5;
      op_word   = 1'b0;
      rs1       = 64'd1000;
      rs2       = 64'd3;
      req_valid = 1'b1;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge g_clk);
      #1;
      flush = 1'b1;
      @(posedge g_clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy); end
      flush = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL flush_req_ready: got %b want 1", req_ready); end
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge g_clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_rsp: got rsp_valid seen=%b want 0", seen); end
      run_op(3'd0, 1'b0, 64'd6, 64'd7, lat, res);
      n_cmp++; if (res !== 64'd42) begin n_err++; $display("FAIL flush_next_mul_res: got %0d want 42", res); end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL flush_next_mul_lat: got %0d want 33", lat); end
      // flush coincident with a request in IDLE blocks the accept
      op_sel    = 3'd0;
      rs1       = 64'd3;
      rs2       = 64'd3;
      req_valid = 1'b1;
      flush     = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_req_ready_low: got %b want 0", req_ready); end
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_no_accept_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_op();
      int lat;
      logic [63:0] res;
      op_sel    = 3'd5;
      op_word   = 1'b0;
      rs1       = 64'd1000;
      rs2       = 64'd3;
      req_valid = 1'b1;
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge g_clk);
      #1;
      g_resetn = 1'b0;
      @(posedge g_clk); #1;
      n_cmp++; if (rsp_rd !== 64'h0) begin n_err++; $display("FAIL midreset_rsp_rd: got %h want 0", rsp_rd); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", busy); end
      g_resetn = 1'b1;
      @(posedge g_clk); #1;
      run_op(3'd5, 1'b0, 64'd1000, 64'd3, lat, res);
      n_cmp++; if (res !== 64'd333) begin n_err++; $display("FAIL midreset_divu_res: got %0d want 333", res); end
      n_cmp++; if (lat !== 66) begin n_err++; $display("FAIL midreset_divu_lat: got %0d want 66", lat); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_word_mul();
      test_backpressure();
      test_flush();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
